// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard controller for the 5-stage core. It sits beside the pipeline
// registers and drives their hold / NOP-load / flush controls. It covers:
//   - load-use stall detection
//   - EX operand forwarding select
//   - variable-latency data-memory wait stalls, with a timeout FSM
//   - branch flush of IF/ID
//   - saturating performance counters
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   *_id                ID-stage register reads and taken-branch indication
//   *_ex                EX-stage operand usage, destination and load flag
//   *_mem, *_wb         MEM/WB destinations and write enables (forward sources)
//   dmem_req/dmem_ack   MEM-stage access handshake
//   err_clr             one-cycle pulse that clears the timeout error
//   cnt_clr             clears all perf counters
//   stall               per-stage hold: bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM,
//                       4 MEM/WB, 5 WB
//   bubble_ex/bubble_wb load ID/EX or MEM/WB with a NOP
//   flush_id            load IF/ID with a NOP
//   forward_op1/op2     00 regfile, 01 MEM, 10 WB
//   dmem_timeout        sticky timeout error
//   cnt_*               saturating event counters
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no outstanding memory access
// S_WAIT  | access outstanding; wait_left counts down to the timeout
// S_ERROR | timed out; whole pipe held until err_clr
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int STALL_WIDTH    = 6,
  parameter int MAX_WAIT       = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rs1_rd_en_id,
  input  logic                      rs2_rd_en_id,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_id,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_id,
  input  logic                      branch_taken_id,
  input  logic                      rs1_rd_en_ex,
  input  logic                      rs2_rd_en_ex,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_ex,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_ex,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_ex,
  input  logic                      mem_read_ex,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_mem,
  input  logic                      reg_write_mem,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_wb,
  input  logic                      reg_write_wb,
  input  logic                      dmem_req,
  input  logic                      dmem_ack,
  input  logic                      err_clr,
  input  logic                      cnt_clr,
  output logic [STALL_WIDTH-1:0]    stall,
  output logic                      bubble_ex,
  output logic                      bubble_wb,
  output logic                      flush_id,
  output logic [1:0]                forward_op1,
  output logic [1:0]                forward_op2,
  output logic                      dmem_timeout,
  output logic [CNT_WIDTH-1:0]      cnt_load_use,
  output logic [CNT_WIDTH-1:0]      cnt_mem_wait,
  output logic [CNT_WIDTH-1:0]      cnt_flush
);

  localparam int WCW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  // wait_left is loaded on entry to S_WAIT; reaching zero without an ack
  // is the MAX_WAIT-1'th cycle in S_WAIT.
  localparam logic [WCW-1:0]         WAIT_LOAD = WCW'(MAX_WAIT - 2);
  localparam logic [STALL_WIDTH-1:0] STALL_MEM = STALL_WIDTH'(4'b1111);
  localparam logic [STALL_WIDTH-1:0] STALL_LU  = STALL_WIDTH'(2'b11);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t               state;
  logic [WCW-1:0]       wait_left;
  logic                 branch_pend;

  logic                 in_error;
  logic                 mem_wait;
  logic                 lu_hit;
  logic                 load_use;
  logic                 any_stall;
  logic                 flush_c;
  logic [STALL_WIDTH-1:0] stall_c;
  logic [1:0]           fwd1_c;
  logic [1:0]           fwd2_c;

  // ---------------------------------------------------------------
  // Hazard classification, highest priority first
  // ---------------------------------------------------------------
  assign in_error = (state == S_ERROR);
  assign mem_wait = !in_error && dmem_req && !dmem_ack;
  assign lu_hit   = mem_read_ex && (rd_addr_ex != '0) &&
                    ((rs1_rd_en_id && (rs1_addr_id == rd_addr_ex)) ||
                     (rs2_rd_en_id && (rs2_addr_id == rd_addr_ex)));
  assign load_use  = !in_error && !mem_wait && lu_hit;
  assign any_stall = in_error || mem_wait || load_use;
  // A branch resolved while stalled is remembered so it still flushes
  // even if ID has already dropped the indication.
  assign flush_c   = !any_stall && (branch_taken_id || branch_pend);

  always_comb begin
    stall_c = '0;
    if (in_error)      stall_c = '1;
    else if (mem_wait) stall_c = STALL_MEM;
    else if (load_use) stall_c = STALL_LU;
  end

  // ---------------------------------------------------------------
  // Forwarding: MEM beats WB, x0 never forwards
  // ---------------------------------------------------------------
  always_comb begin
    fwd1_c = 2'b00;
    if (rs1_rd_en_ex && reg_write_mem && (rd_addr_mem == rs1_addr_ex) && (rd_addr_mem != '0))
      fwd1_c = 2'b01;
    else if (rs1_rd_en_ex && reg_write_wb && (rd_addr_wb == rs1_addr_ex) && (rd_addr_wb != '0))
      fwd1_c = 2'b10;
  end

  always_comb begin
    fwd2_c = 2'b00;
    if (rs2_rd_en_ex && reg_write_mem && (rd_addr_mem == rs2_addr_ex) && (rd_addr_mem != '0))
      fwd2_c = 2'b01;
    else if (rs2_rd_en_ex && reg_write_wb && (rd_addr_wb == rs2_addr_ex) && (rd_addr_wb != '0))
      fwd2_c = 2'b10;
  end

  // Combinational outputs are forced low while reset is asserted.
  assign stall       = rst ? stall_c  : '0;
  assign bubble_ex   = rst && load_use;
  assign bubble_wb   = rst && mem_wait;
  assign flush_id    = rst && flush_c;
  assign forward_op1 = rst ? fwd1_c   : 2'b00;
  assign forward_op2 = rst ? fwd2_c   : 2'b00;

  // ---------------------------------------------------------------
  // Memory wait / timeout FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      wait_left    <= '0;
      dmem_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dmem_req && !dmem_ack) begin
            state     <= S_WAIT;
            wait_left <= WAIT_LOAD;
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            state <= S_IDLE;
          end else if (wait_left == '0) begin
            state        <= S_ERROR;
            dmem_timeout <= 1'b1;
          end else begin
            wait_left <= wait_left - WCW'(1);
          end
        end
        S_ERROR: begin
          if (err_clr) begin
            state        <= S_IDLE;
            dmem_timeout <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Pending branch flush
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_pend <= 1'b0;
    end else if (flush_c) begin
      branch_pend <= 1'b0;
    end else if (branch_taken_id && any_stall) begin
      branch_pend <= 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Saturating performance counters; clear wins over increment
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_load_use <= '0;
      cnt_mem_wait <= '0;
      cnt_flush    <= '0;
    end else if (cnt_clr) begin
      cnt_load_use <= '0;
      cnt_mem_wait <= '0;
      cnt_flush    <= '0;
    end else begin
      if (load_use && (cnt_load_use != '1)) cnt_load_use <= cnt_load_use + CNT_ONE;
      if (mem_wait && (cnt_mem_wait != '1)) cnt_mem_wait <= cnt_mem_wait + CNT_ONE;
      if (flush_c  && (cnt_flush    != '1)) cnt_flush    <= cnt_flush    + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  localparam int RAW  = 5;
  localparam int SW   = 6;
  localparam int MW   = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic rs1_rd_en_id, rs2_rd_en_id, branch_taken_id;
  logic [RAW-1:0] rs1_addr_id, rs2_addr_id;
  logic rs1_rd_en_ex, rs2_rd_en_ex, mem_read_ex;
  logic [RAW-1:0] rs1_addr_ex, rs2_addr_ex, rd_addr_ex;
  logic [RAW-1:0] rd_addr_mem, rd_addr_wb;
  logic reg_write_mem, reg_write_wb;
  logic dmem_req, dmem_ack, err_clr, cnt_clr;
  logic [SW-1:0] stall;
  logic bubble_ex, bubble_wb, flush_id, dmem_timeout;
  logic [1:0] forward_op1, forward_op2;
  logic [CW-1:0] cnt_load_use, cnt_mem_wait, cnt_flush;

  pipe_hazard_ctrl #(
    .REG_ADDR_WIDTH(RAW), .STALL_WIDTH(SW), .MAX_WAIT(MW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .rs1_rd_en_id(rs1_rd_en_id), .rs2_rd_en_id(rs2_rd_en_id),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
    .branch_taken_id(branch_taken_id),
    .rs1_rd_en_ex(rs1_rd_en_ex), .rs2_rd_en_ex(rs2_rd_en_ex),
    .rs1_addr_ex(rs1_addr_ex), .rs2_addr_ex(rs2_addr_ex),
    .rd_addr_ex(rd_addr_ex), .mem_read_ex(mem_read_ex),
    .rd_addr_mem(rd_addr_mem), .reg_write_mem(reg_write_mem),
    .rd_addr_wb(rd_addr_wb), .reg_write_wb(reg_write_wb),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .err_clr(err_clr), .cnt_clr(cnt_clr),
    .stall(stall), .bubble_ex(bubble_ex), .bubble_wb(bubble_wb),
    .flush_id(flush_id), .forward_op1(forward_op1), .forward_op2(forward_op2),
    .dmem_timeout(dmem_timeout),
    .cnt_load_use(cnt_load_use), .cnt_mem_wait(cnt_mem_wait), .cnt_flush(cnt_flush)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: error flag, number of cycles the current access has
  // been outstanding, remembered branch, and plain integer counters.
  bit m_err;
  int m_waited;
  bit m_pend;
  int m_lu, m_mw, m_fl;
  bit e_mw, e_lu, e_fl;
  logic [SW-1:0] e_stall;

  function automatic int fwd_ref(bit en, logic [RAW-1:0] a);
    if (en && reg_write_mem && rd_addr_mem == a && rd_addr_mem != 0) return 1;
    if (en && reg_write_wb && rd_addr_wb == a && rd_addr_wb != 0) return 2;
    return 0;
  endfunction

  function automatic int sat_inc(int v, bit ev);
    return (v + ev > CMAX) ? CMAX : v + ev;
  endfunction

  task automatic model_reset();
    m_err = 0; m_waited = 0; m_pend = 0;
    m_lu = 0; m_mw = 0; m_fl = 0;
  endtask

  task automatic eval();
    e_mw = !m_err && dmem_req && !dmem_ack;
    e_lu = !m_err && !e_mw && mem_read_ex && rd_addr_ex != 0 &&
           ((rs1_rd_en_id && rs1_addr_id == rd_addr_ex) ||
            (rs2_rd_en_id && rs2_addr_id == rd_addr_ex));
    e_fl = !(m_err || e_mw || e_lu) && (branch_taken_id || m_pend);
    if (m_err)     e_stall = {SW{1'b1}};
    else if (e_mw) e_stall = SW'(6'h0f);
    else if (e_lu) e_stall = SW'(6'h03);
    else           e_stall = '0;
  endtask

  task automatic check_all();
    eval();
    chk("stall", stall, e_stall);
    chk("bubble_ex", bubble_ex, e_lu);
    chk("bubble_wb", bubble_wb, e_mw);
    chk("flush_id", flush_id, e_fl);
    chk("fwd_op1", forward_op1, fwd_ref(rs1_rd_en_ex, rs1_addr_ex));
    chk("fwd_op2", forward_op2, fwd_ref(rs2_rd_en_ex, rs2_addr_ex));
    chk("dmem_timeout", dmem_timeout, m_err);
    chk("cnt_load_use", cnt_load_use, m_lu);
    chk("cnt_mem_wait", cnt_mem_wait, m_mw);
    chk("cnt_flush", cnt_flush, m_fl);
  endtask

  task automatic model_tick();
    bit anys;
    anys = m_err || e_mw || e_lu;
    if (cnt_clr) begin
      m_lu = 0; m_mw = 0; m_fl = 0;
    end else begin
      m_lu = sat_inc(m_lu, e_lu);
      m_mw = sat_inc(m_mw, e_mw);
      m_fl = sat_inc(m_fl, e_fl);
    end
    if (e_fl) m_pend = 0;
    else if (branch_taken_id && anys) m_pend = 1;
    if (m_err) begin
      if (err_clr) m_err = 0;
    end else if (m_waited == 0) begin
      if (dmem_req && !dmem_ack) m_waited = 1;
    end else if (dmem_ack) begin
      m_waited = 0;
    end else if (m_waited == MW - 1) begin
      m_err = 1; m_waited = 0;
    end else begin
      m_waited++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle_in();
    rs1_rd_en_id = 0; rs2_rd_en_id = 0; rs1_addr_id = 0; rs2_addr_id = 0;
    branch_taken_id = 0; rs1_rd_en_ex = 0; rs2_rd_en_ex = 0;
    rs1_addr_ex = 0; rs2_addr_ex = 0; rd_addr_ex = 0; mem_read_ex = 0;
    rd_addr_mem = 0; reg_write_mem = 0; rd_addr_wb = 0; reg_write_wb = 0;
    dmem_req = 0; dmem_ack = 0; err_clr = 0; cnt_clr = 0;
  endtask

  task automatic clear_counters();
    idle_in();
    cnt_clr = 1;
    step();
    cnt_clr = 0;
  endtask

  int ack_pct;

  initial begin
    rst = 0;
    idle_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_timeout", dmem_timeout, 0);
    rst = 1;

    // Reset in the middle of a wait, with forwarding inputs matching
    dmem_req = 1;
    repeat (5) step();
    rs1_rd_en_ex = 1; rs1_addr_ex = 3; rd_addr_mem = 3; reg_write_mem = 1;
    #1;
    chk("pre_rst_stall", stall, 6'h0f);
    rst = 0;
    #1;
    model_reset();
    chk("rstmid_stall", stall, 0);
    chk("rstmid_fwd1", forward_op1, 0);
    chk("rstmid_bubble_wb", bubble_wb, 0);
    chk("rstmid_cnt_mem_wait", cnt_mem_wait, 0);
    @(posedge clk);
    #1;
    idle_in();
    rst = 1;
    repeat (3) step();

    // Forwarding
    rs1_rd_en_ex = 1; rs1_addr_ex = 3;
    rd_addr_mem = 3; reg_write_mem = 1; rd_addr_wb = 3; reg_write_wb = 1;
    #1 chk("fwd_mem", forward_op1, 2'b01);
    step();
    reg_write_mem = 0;
    #1 chk("fwd_wb", forward_op1, 2'b10);
    step();
    reg_write_mem = 1; rd_addr_mem = 0; rd_addr_wb = 0;
    #1 chk("fwd_x0", forward_op1, 2'b00);
    step();
    rs2_rd_en_ex = 1; rs2_addr_ex = 7; rd_addr_mem = 7; rd_addr_wb = 7;
    #1 chk("fwd2_mem", forward_op2, 2'b01);
    step();

    // Load-use
    clear_counters();
    mem_read_ex = 1; rd_addr_ex = 5; rs2_addr_id = 5; rs2_rd_en_id = 1;
    #1 chk("lu_stall", stall, 6'h03);
    chk("lu_bubble_ex", bubble_ex, 1);
    step();
    idle_in();
    #1 chk("lu_cnt", cnt_load_use, 1);
    step();

    // Memory wait of three cycles
    clear_counters();
    dmem_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mw_stall", stall, 6'h0f);
      step();
    end
    dmem_ack = 1;
    #1 chk("mw_ack_stall", stall, 0);
    step();
    idle_in();
    #1 chk("mw_cnt", cnt_mem_wait, 3);
    step();

    // Memory wait coinciding with load-use
    dmem_req = 1;
    mem_read_ex = 1; rd_addr_ex = 9; rs1_addr_id = 9; rs1_rd_en_id = 1;
    #1 chk("mwlu_stall", stall, 6'h0f);
    chk("mwlu_bubble_ex", bubble_ex, 0);
    step();
    dmem_ack = 1;
    #1 chk("mwlu_after", stall, 6'h03);
    step();
    idle_in();
    step();

    // Timeout
    dmem_req = 1;
    repeat (15) step();
    chk("to_not_yet", dmem_timeout, 0);
    step();
    chk("to_rise", dmem_timeout, 1);
    chk("to_stall", stall, 6'h3f);
    dmem_req = 0;
    step();
    err_clr = 1;
    step();
    err_clr = 0;
    #1 chk("to_clr_stall", stall, 0);
    chk("to_clr_flag", dmem_timeout, 0);
    step();

    // Branch seen during a memory wait
    dmem_req = 1; branch_taken_id = 1;
    #1 chk("br_in_wait", flush_id, 0);
    step();
    branch_taken_id = 0;
    step();
    dmem_ack = 1;
    #1 chk("br_first_free", flush_id, 1);
    step();
    idle_in();
    #1 chk("br_once", flush_id, 0);
    step();

    // Flush counter saturation and clear
    clear_counters();
    branch_taken_id = 1;
    repeat (20) step();
    chk("fl_sat", cnt_flush, CMAX);
    cnt_clr = 1;
    step();
    idle_in();
    #1 chk("fl_clr", cnt_flush, 0);
    step();

    // Randomized traffic
    ack_pct = 70;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: ack_pct = 70;
          1: ack_pct = 30;
          default: ack_pct = 3;
        endcase
      end
      rs1_rd_en_id    = 1'($urandom_range(0, 1));
      rs2_rd_en_id    = 1'($urandom_range(0, 1));
      rs1_addr_id     = RAW'($urandom_range(0, 3));
      rs2_addr_id     = RAW'($urandom_range(0, 3));
      branch_taken_id = ($urandom_range(0, 99) < 20);
      rs1_rd_en_ex    = 1'($urandom_range(0, 1));
      rs2_rd_en_ex    = 1'($urandom_range(0, 1));
      rs1_addr_ex     = RAW'($urandom_range(0, 3));
      rs2_addr_ex     = RAW'($urandom_range(0, 3));
      rd_addr_ex      = RAW'($urandom_range(0, 3));
      mem_read_ex     = ($urandom_range(0, 99) < 40);
      rd_addr_mem     = RAW'($urandom_range(0, 3));
      reg_write_mem   = 1'($urandom_range(0, 1));
      rd_addr_wb      = RAW'($urandom_range(0, 3));
      reg_write_wb    = 1'($urandom_range(0, 1));
      dmem_req        = ($urandom_range(0, 99) < 50);
      dmem_ack        = ($urandom_range(0, 99) < ack_pct);
      err_clr         = ($urandom_range(0, 99) < 5);
      cnt_clr         = ($urandom_range(0, 99) < 1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
